// File: rtl/if_fetch_unit.sv
// ============================================================================
// Module  : if_fetch_unit
// Brief   : Instruction-fetch stage with req/gnt/rvalid memory port, stall
//           hold buffer and branch/jump redirect. Optional macro
//           FETCH_PERF_CNT_EN adds fetch/drop performance counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] fetch_pcincre,
  output logic [31:0] fetch_instr,
  output logic        fetch_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_drop_cnt
`endif
);

  localparam logic [31:0] c_PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] r_req_pc;
  logic        r_drop;
  logic        w_drop_next;
  logic [31:0] r_hold_instr;
  logic [31:0] r_hold_pcincre;
  logic        w_grant;
  logic        w_capture;
  logic        w_discard;
  logic        w_load;
  logic [31:0] w_load_instr;
  logic [31:0] w_load_pcincre;
  logic [31:0] r_fetch_pcincre;
  logic [31:0] r_fetch_instr;
  logic        r_fetch_valid;

  always_comb begin
    w_next_state   = r_state;
    w_drop_next    = r_drop;
    w_grant        = 1'b0;
    w_capture      = 1'b0;
    w_discard      = 1'b0;
    w_load         = 1'b0;
    w_load_instr   = '0;
    w_load_pcincre = '0;
    case (r_state)
      S_FETCH: begin
        if (imem_gnt) begin
          w_grant      = 1'b1;
          w_drop_next  = redirect_en;
          w_next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          w_next_state = S_FETCH;
          w_drop_next  = 1'b0;
          if (r_drop || redirect_en) begin
            w_discard = 1'b1;
          end else if (!id_stall) begin
            w_load         = 1'b1;
            w_load_instr   = imem_rdata;
            w_load_pcincre = r_req_pc + c_PC_STEP;
          end else begin
            w_capture    = 1'b1;
            w_next_state = S_HOLD;
          end
        end else if (redirect_en) begin
          // Response still in flight: mark it stale so it is thrown away later.
          w_drop_next = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_en) begin
          w_next_state = S_FETCH;
        end else if (!id_stall) begin
          w_load         = 1'b1;
          w_load_instr   = r_hold_instr;
          w_load_pcincre = r_hold_pcincre;
          w_next_state   = S_FETCH;
        end
      end
      default: w_next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_FETCH;
      r_pc           <= RESET_PC;
      r_req_pc       <= '0;
      r_drop         <= 1'b0;
      r_hold_instr   <= '0;
      r_hold_pcincre <= '0;
    end else begin
      r_state <= w_next_state;
      r_drop  <= w_drop_next;
      if (redirect_en) begin
        r_pc <= {redirect_pc[31:2], 2'b00};
      end else if (w_grant) begin
        r_pc <= r_pc + c_PC_STEP;
      end
      if (w_grant) begin
        r_req_pc <= r_pc;
      end
      if (redirect_en) begin
        r_hold_instr   <= '0;
        r_hold_pcincre <= '0;
      end else if (w_capture) begin
        r_hold_instr   <= imem_rdata;
        r_hold_pcincre <= r_req_pc + c_PC_STEP;
      end
    end
  end

  // Redirect flushes, a load publishes, otherwise a bubble unless stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pcincre <= '0;
      r_fetch_instr   <= '0;
      r_fetch_valid   <= 1'b0;
    end else if (redirect_en) begin
      r_fetch_instr <= '0;
      r_fetch_valid <= 1'b0;
    end else if (w_load) begin
      r_fetch_pcincre <= w_load_pcincre;
      r_fetch_instr   <= w_load_instr;
      r_fetch_valid   <= 1'b1;
    end else if (!id_stall) begin
      r_fetch_instr <= '0;
      r_fetch_valid <= 1'b0;
    end
  end

  assign imem_req      = (r_state == S_FETCH) && !rst;
  assign imem_addr     = r_pc;
  assign fetch_pcincre = r_fetch_pcincre;
  assign fetch_instr   = r_fetch_instr;
  assign fetch_valid   = r_fetch_valid;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetch_cnt;
  logic [31:0] r_perf_drop_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_fetch_cnt <= '0;
      r_perf_drop_cnt  <= '0;
    end else begin
      if (w_load && !redirect_en) begin
        r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
      end
      if (w_discard) begin
        r_perf_drop_cnt <= r_perf_drop_cnt + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt = r_perf_fetch_cnt;
  assign perf_drop_cnt  = r_perf_drop_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// ============================================================================
// Module  : tb_if_fetch_unit
// Brief   : Self-checking bench for if_fetch_unit (directed + random traffic
//           against a transaction-level reference model).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_stall, redirect_en, imem_gnt, imem_rvalid;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, fetch_valid;
  logic [31:0] imem_addr, fetch_pcincre, fetch_instr;

  logic        req2, valid2, rv2;
  logic [31:0] addr2, pcinc2, instr2;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_drop_cnt, pf2, pd2;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .id_stall(id_stall), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .fetch_pcincre(fetch_pcincre), .fetch_instr(fetch_instr), .fetch_valid(fetch_valid)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_drop_cnt(perf_drop_cnt)
`endif
  );

  // Second instance exercises the wrap-around reset PC with a zero-wait memory.
  assign rv2 = ~req2;
  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .id_stall(1'b0), .redirect_en(1'b0),
    .redirect_pc(32'h0), .imem_req(req2), .imem_addr(addr2),
    .imem_gnt(1'b1), .imem_rvalid(rv2), .imem_rdata(32'h1234_5678),
    .fetch_pcincre(pcinc2), .fetch_instr(instr2), .fetch_valid(valid2)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cnt(pf2), .perf_drop_cnt(pd2)
`endif
  );

  // Transaction-level reference: one outstanding request, one buffered response.
  logic        m_in_rst;
  logic [31:0] m_pc;
  logic        m_busy, m_dead, m_held;
  logic [31:0] m_busy_pc, m_held_pc, m_held_instr;
  logic        m_valid;
  logic [31:0] m_instr, m_pcinc;
  logic [31:0] m_fetches, m_drops;

  function automatic logic m_req();
    return !m_in_rst && !m_busy && !m_held;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_busy = 0; m_dead = 0; m_held = 0;
    m_busy_pc = 0; m_held_pc = 0; m_held_instr = 0;
    m_valid = 0; m_instr = 0; m_pcinc = 0; m_fetches = 0; m_drops = 0;
  endtask

  task automatic model_update(input logic st, input logic rd, input logic [31:0] rpc,
                              input logic gn, input logic rv, input logic [31:0] rdat);
    logic        load;
    logic [31:0] li, lp;
    load = 0; li = 0; lp = 0;
    if (m_req()) begin
      if (gn) begin
        m_busy = 1; m_busy_pc = m_pc; m_dead = rd; m_pc = m_pc + 32'd4;
      end
    end else if (m_busy) begin
      if (rv) begin
        m_busy = 0;
        if (m_dead || rd) m_drops = m_drops + 1;
        else if (!st) begin load = 1; lp = m_busy_pc + 32'd4; li = rdat; end
        else begin m_held = 1; m_held_pc = m_busy_pc + 32'd4; m_held_instr = rdat; end
        m_dead = 0;
      end else if (rd) m_dead = 1;
    end else begin
      if (rd) m_held = 0;
      else if (!st) begin load = 1; lp = m_held_pc; li = m_held_instr; m_held = 0; end
    end
    if (rd) m_pc = {rpc[31:2], 2'b00};
    if (rd) begin
      m_valid = 0; m_instr = 0;
    end else if (load) begin
      m_valid = 1; m_instr = li; m_pcinc = lp; m_fetches = m_fetches + 1;
    end else if (!st) begin
      m_valid = 0; m_instr = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_req"}, {31'b0, imem_req}, {31'b0, m_req()});
    if (m_req()) chk({tag, "_addr"}, imem_addr, m_pc);
    chk({tag, "_valid"}, {31'b0, fetch_valid}, {31'b0, m_valid});
    chk({tag, "_instr"}, fetch_instr, m_instr);
    chk({tag, "_pcinc"}, fetch_pcincre, m_pcinc);
`ifdef FETCH_PERF_CNT_EN
    chk({tag, "_pfetch"}, perf_fetch_cnt, m_fetches);
    chk({tag, "_pdrop"}, perf_drop_cnt, m_drops);
`endif
  endtask

  // Called at a falling edge: drive, advance one cycle, check at the next falling edge.
  task automatic step(input string tag, input logic st, input logic rd, input logic [31:0] rpc,
                      input logic gn, input logic rv, input logic [31:0] rdat);
    id_stall = st; redirect_en = rd; redirect_pc = rpc;
    imem_gnt = gn; imem_rvalid = rv; imem_rdata = rdat;
    model_update(st, rd, rpc, gn, rv, rdat);
    @(posedge clk);
    @(negedge clk);
    id_stall = 0; redirect_en = 0; imem_gnt = 0; imem_rvalid = 0;
    check_outputs(tag);
  endtask

  initial begin
    rst = 1; id_stall = 0; redirect_en = 0; redirect_pc = 0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    model_reset(); m_in_rst = 1;
    repeat (2) @(negedge clk);
    check_outputs("reset");
    chk("reset_req2", {31'b0, req2}, 32'd0);

    // Reset release: first request at RESET_PC right away.
    rst = 0; m_in_rst = 0;
    #1;
    check_outputs("release");
    chk("t1_addr0", imem_addr, 32'h0);
    chk("t5_addr0", addr2, 32'hFFFF_FFFC);

    // Back-to-back fetches with one-cycle memory latency.
    step("t1_g0", 0, 0, 0, 1, 0, 0);
    step("t1_r0", 0, 0, 0, 0, 1, 32'h2002_0005);
    chk("t1_pcinc4", fetch_pcincre, 32'd4);
    chk("t1_valid", {31'b0, fetch_valid}, 32'd1);
    chk("t1_addr4", imem_addr, 32'd4);
    chk("t5_pcinc", pcinc2, 32'd0);
    chk("t5_valid", {31'b0, valid2}, 32'd1);
    chk("t5_addr", addr2, 32'd0);
    step("t1_g1", 0, 0, 0, 1, 0, 0);
    step("t1_r1", 0, 0, 0, 0, 1, 32'h2002_0005);
    chk("t1_addr8", imem_addr, 32'd8);

    // Response arrives under a three-cycle stall.
    step("t2_g", 0, 0, 0, 1, 0, 0);
    step("t2_r", 1, 0, 0, 0, 1, 32'hCAFE_0001);
    step("t2_s1", 1, 0, 0, 0, 0, 0);
    step("t2_s2", 1, 0, 0, 0, 0, 0);
    chk("t2_held_valid", {31'b0, fetch_valid}, 32'd0);
    step("t2_go", 0, 0, 0, 0, 0, 0);
    chk("t2_instr", fetch_instr, 32'hCAFE_0001);
    chk("t2_pcinc", fetch_pcincre, 32'd12);

    // Redirect while waiting for a response.
    step("t3_g", 0, 0, 0, 1, 0, 0);
    step("t3_rd", 0, 1, 32'h0000_0103, 0, 0, 0);
    step("t3_r", 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    chk("t3_valid", {31'b0, fetch_valid}, 32'd0);
    chk("t3_addr", imem_addr, 32'h0000_0100);

    // Redirect coincident with grant.
    step("t4_g", 0, 1, 32'h0000_0200, 1, 0, 0);
    step("t4_r", 0, 0, 0, 0, 1, 32'hBAD0_0BAD);
    chk("t4_valid", {31'b0, fetch_valid}, 32'd0);
    chk("t4_addr", imem_addr, 32'h0000_0200);

    // Asynchronous reset in the middle of a transaction.
    step("t6_g", 0, 0, 0, 1, 0, 0);
    #2 rst = 1;
    #1;
    model_reset(); m_in_rst = 1;
    check_outputs("t6_rst");
    @(negedge clk);
    rst = 0; m_in_rst = 0;
    #1;
    check_outputs("t6_rel");
    chk("t6_addr", imem_addr, 32'h0);

    // Randomized traffic: variable latency, stalls, redirects, stray rvalids.
    for (int i = 0; i < 1500; i++) begin
      logic st, rd, gn, rv;
      st = ($urandom % 4) == 0;
      rd = ($urandom % 10) == 0;
      gn = m_req() && (($urandom % 3) != 0);
      rv = m_busy ? logic'($urandom % 2) : (($urandom % 25) == 0);
      step("rand", st, rd, $urandom, gn, rv, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
